// File: rtl/chanbuf_pkg.sv
// Shared types and sizing helpers for the channel-buffer port arbiter.
// Contents: per-channel FSM state enum, select-width and counter-width helpers.
// Optional feature macro used by the arbiter files: CHANBUF_PREEMPT_EN.
package chanbuf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_t;

    // Width of an index into n items, never less than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 1) ? 32'd1 : 32'($clog2(n));
    endfunction

    // Width of a counter that must hold values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 32'd1 : 32'($clog2(max_val + 1));
    endfunction

endpackage

// File: rtl/chanbuf_rr_arbiter.sv
// Per-channel round-robin arbiter with ownership lock.
// Ports: master_clk/n_reset, mod_req and mod_chan_sel from all modules,
//        mod_clken (burst counting, CHANBUF_PREEMPT_EN only),
//        busy_c (channel owned), grant_c (one-hot owner), preempt (registered pulse).
// Macro: CHANBUF_PREEMPT_EN builds the burst counter and forced release.
module chanbuf_rr_arbiter
    import chanbuf_pkg::*;
#(
    parameter int unsigned NUM_MODS  = 4,
    parameter int unsigned NUM_CHANS = 4,
    parameter int unsigned CHAN_IDX  = 0
`ifdef CHANBUF_PREEMPT_EN
    ,
    parameter int unsigned BURST_MAX = 64
`endif
) (
    input  logic                                      master_clk,
    input  logic                                      n_reset,
    input  logic [NUM_MODS-1:0]                       mod_req,
    input  logic [NUM_MODS*sel_width(NUM_CHANS)-1:0]  mod_chan_sel,
`ifdef CHANBUF_PREEMPT_EN
    input  logic [NUM_MODS-1:0]                       mod_clken,
`endif
    output logic                                      busy_c,
    output logic [NUM_MODS-1:0]                       grant_c,
    output logic [NUM_MODS-1:0]                       preempt
);

    localparam int unsigned SEL_W = sel_width(NUM_CHANS);
    localparam int unsigned OWN_W = sel_width(NUM_MODS);
`ifdef CHANBUF_PREEMPT_EN
    localparam int unsigned CNT_W = cnt_width(BURST_MAX);
`endif

    arb_state_t          state_q, state_d;
    logic [OWN_W-1:0]    owner_q, owner_d;
    logic [OWN_W-1:0]    last_q, last_d;
    logic [NUM_MODS-1:0] preempt_d;
    logic [NUM_MODS-1:0] hit_c;
    logic                pick_vld_c;
    logic [OWN_W-1:0]    pick_c;
`ifdef CHANBUF_PREEMPT_EN
    logic [CNT_W-1:0]    burst_q, burst_d;
    logic                rival_c;
`endif

    // Valid requesters for this channel; an out-of-range select never matches.
    always_comb begin
        hit_c = '0;
        for (int unsigned m = 0; m < NUM_MODS; m++) begin
            hit_c[m] = mod_req[m] && (mod_chan_sel[m*SEL_W +: SEL_W] == SEL_W'(CHAN_IDX));
        end
    end

    // Round-robin pick starting one past the last owner.
    always_comb begin
        pick_vld_c = 1'b0;
        pick_c     = '0;
        for (int unsigned k = 1; k <= NUM_MODS; k++) begin
            if (!pick_vld_c && hit_c[OWN_W'((32'(last_q) + k) % NUM_MODS)]) begin
                pick_vld_c = 1'b1;
                pick_c     = OWN_W'((32'(last_q) + k) % NUM_MODS);
            end
        end
    end

`ifdef CHANBUF_PREEMPT_EN
    // Another valid requester is waiting behind the owner.
    always_comb begin
        rival_c = 1'b0;
        for (int unsigned m = 0; m < NUM_MODS; m++) begin
            if (hit_c[m] && (owner_q != OWN_W'(m))) begin
                rival_c = 1'b1;
            end
        end
    end
`endif

    // State register.
    always_ff @(posedge master_clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= OWN_W'(NUM_MODS - 1);
            preempt <= '0;
`ifdef CHANBUF_PREEMPT_EN
            burst_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            preempt <= preempt_d;
`ifdef CHANBUF_PREEMPT_EN
            burst_q <= burst_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        preempt_d = '0;
`ifdef CHANBUF_PREEMPT_EN
        burst_d   = burst_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_vld_c) begin
                    state_d = ST_OWNED;
                    owner_d = pick_c;
                    last_d  = pick_c;
`ifdef CHANBUF_PREEMPT_EN
                    burst_d = '0;
`endif
                end
            end
            ST_OWNED: begin
                if (!hit_c[owner_q]) begin
                    state_d = ST_TURN;
                end
`ifdef CHANBUF_PREEMPT_EN
                else if ((burst_q == CNT_W'(BURST_MAX)) && rival_c) begin
                    state_d            = ST_TURN;
                    preempt_d[owner_q] = 1'b1;
                end else if (mod_clken[owner_q] && (burst_q != CNT_W'(BURST_MAX))) begin
                    burst_d = burst_q + CNT_W'(1);
                end
`endif
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state.
    always_comb begin
        busy_c  = (state_q == ST_OWNED);
        grant_c = '0;
        if (busy_c) begin
            grant_c[owner_q] = 1'b1;
        end
    end

endmodule

// File: rtl/chanbuf_port_arbiter.sv
// Request/grant arbiter between module controllers and channel-buffer input ports.
// Ports: master_clk/n_reset; per-module mod_req, mod_chan_sel, strobes, write data,
//        returned read data, grant and preempt pulse; per-channel strobes, address,
//        write data, read data and busy. Buses are flattened, index 0 in the LSBs.
// Macro: CHANBUF_PREEMPT_EN enables burst-length preemption.
module chanbuf_port_arbiter
    import chanbuf_pkg::*;
#(
    parameter int unsigned NUM_MODS  = 4,
    parameter int unsigned NUM_CHANS = 4,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned BURST_MAX = 64
) (
    input  logic                                      master_clk,
    input  logic                                      n_reset,
    input  logic [NUM_MODS-1:0]                       mod_req,
    input  logic [NUM_MODS*sel_width(NUM_CHANS)-1:0]  mod_chan_sel,
    input  logic [NUM_MODS-1:0]                       mod_clken,
    input  logic [NUM_MODS-1:0]                       mod_we,
    input  logic [NUM_MODS*ADDR_W-1:0]                mod_addr,
    input  logic [NUM_MODS*DATA_W-1:0]                mod_data_i,
    output logic [NUM_MODS*DATA_W-1:0]                mod_data_o,
    output logic [NUM_MODS-1:0]                       mod_grant,
    output logic [NUM_MODS-1:0]                       mod_preempt,
    output logic [NUM_CHANS-1:0]                      chan_clken,
    output logic [NUM_CHANS-1:0]                      chan_we,
    output logic [NUM_CHANS*ADDR_W-1:0]               chan_addr,
    output logic [NUM_CHANS*DATA_W-1:0]               chan_data_i,
    input  logic [NUM_CHANS*DATA_W-1:0]               chan_data_o,
    output logic [NUM_CHANS-1:0]                      chan_busy
);

    logic [NUM_MODS-1:0] chan_grant_c [NUM_CHANS];
    logic [NUM_MODS-1:0] chan_preempt [NUM_CHANS];

    // Elaboration-time parameter sanity check.
    if ((NUM_MODS < 2) || (NUM_CHANS < 1) || (BURST_MAX < 1)) begin : g_param_check
        $error("chanbuf_port_arbiter: illegal parameter set");
    end

    // One independent arbiter per channel.
    for (genvar c = 0; c < NUM_CHANS; c++) begin : g_chan
        chanbuf_rr_arbiter #(
            .NUM_MODS  (NUM_MODS),
            .NUM_CHANS (NUM_CHANS),
            .CHAN_IDX  (c)
`ifdef CHANBUF_PREEMPT_EN
            ,
            .BURST_MAX (BURST_MAX)
`endif
        ) u_arb (
            .master_clk   (master_clk),
            .n_reset      (n_reset),
            .mod_req      (mod_req),
            .mod_chan_sel (mod_chan_sel),
`ifdef CHANBUF_PREEMPT_EN
            .mod_clken    (mod_clken),
`endif
            .busy_c       (chan_busy[c]),
            .grant_c      (chan_grant_c[c]),
            .preempt      (chan_preempt[c])
        );
    end

    // Owner-selected muxes in both directions plus grant/preempt OR-reduction.
    always_comb begin
        chan_clken  = '0;
        chan_we     = '0;
        chan_addr   = '0;
        chan_data_i = '0;
        mod_data_o  = '0;
        mod_grant   = '0;
        mod_preempt = '0;
        for (int unsigned c = 0; c < NUM_CHANS; c++) begin
            for (int unsigned m = 0; m < NUM_MODS; m++) begin
                if (chan_grant_c[c][m]) begin
                    chan_clken[c]                     = mod_clken[m];
                    chan_we[c]                        = mod_we[m];
                    chan_addr[c*ADDR_W +: ADDR_W]     = mod_addr[m*ADDR_W +: ADDR_W];
                    chan_data_i[c*DATA_W +: DATA_W]   = mod_data_i[m*DATA_W +: DATA_W];
                    mod_data_o[m*DATA_W +: DATA_W]    = chan_data_o[c*DATA_W +: DATA_W];
                    mod_grant[m]                      = 1'b1;
                end
                mod_preempt[m] = mod_preempt[m] | chan_preempt[c][m];
            end
        end
    end

endmodule

// File: tb/tb_chanbuf_port_arbiter.sv
// Bench for chanbuf_port_arbiter: directed scenarios followed by random traffic,
// every cycle compared against an ownership-table reference model.
// Three channels are used so that select value 3 is out of range.
module tb_chanbuf_port_arbiter;

    localparam int NM = 4;
    localparam int NC = 3;
    localparam int AW = 9;
    localparam int DW = 8;
    localparam int BM = 4;
    localparam int SW = 2;

    logic              clk;
    logic              n_reset;
    logic [NM-1:0]     mod_req;
    logic [NM*SW-1:0]  mod_chan_sel;
    logic [NM-1:0]     mod_clken;
    logic [NM-1:0]     mod_we;
    logic [NM*AW-1:0]  mod_addr;
    logic [NM*DW-1:0]  mod_data_i;
    logic [NM*DW-1:0]  mod_data_o;
    logic [NM-1:0]     mod_grant;
    logic [NM-1:0]     mod_preempt;
    logic [NC-1:0]     chan_clken;
    logic [NC-1:0]     chan_we;
    logic [NC*AW-1:0]  chan_addr;
    logic [NC*DW-1:0]  chan_data_i;
    logic [NC*DW-1:0]  chan_data_o;
    logic [NC-1:0]     chan_busy;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: owner per channel (-1 = none), pending turn gap, rr pointer, burst.
    int own  [NC];
    int last [NC];
    int cnt  [NC];
    bit turn [NC];
    bit pre  [NM];

    chanbuf_port_arbiter #(
        .NUM_MODS  (NM),
        .NUM_CHANS (NC),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .BURST_MAX (BM)
    ) dut (
        .master_clk   (clk),
        .n_reset      (n_reset),
        .mod_req      (mod_req),
        .mod_chan_sel (mod_chan_sel),
        .mod_clken    (mod_clken),
        .mod_we       (mod_we),
        .mod_addr     (mod_addr),
        .mod_data_i   (mod_data_i),
        .mod_data_o   (mod_data_o),
        .mod_grant    (mod_grant),
        .mod_preempt  (mod_preempt),
        .chan_clken   (chan_clken),
        .chan_we      (chan_we),
        .chan_addr    (chan_addr),
        .chan_data_i  (chan_data_i),
        .chan_data_o  (chan_data_o),
        .chan_busy    (chan_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit valid_req(input int m, input int c);
        return mod_req[m] && (int'(mod_chan_sel[m*SW +: SW]) == c);
    endfunction

    task automatic set_sel(input int m, input int c);
        mod_chan_sel[m*SW +: SW] = SW'(c);
    endtask

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            own[c] = -1; turn[c] = 0; last[c] = NM - 1; cnt[c] = 0;
        end
        for (int m = 0; m < NM; m++) pre[m] = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_clock();
        for (int m = 0; m < NM; m++) pre[m] = 0;
        for (int c = 0; c < NC; c++) begin
            if (own[c] >= 0) begin
                int o;
                bit rival;
                o = own[c];
                rival = 0;
                for (int k = 0; k < NM; k++) if (k != o && valid_req(k, c)) rival = 1;
                if (!valid_req(o, c)) begin
                    own[c] = -1; turn[c] = 1;
                end
`ifdef CHANBUF_PREEMPT_EN
                else if (cnt[c] == BM && rival) begin
                    own[c] = -1; turn[c] = 1; pre[o] = 1;
                end
`endif
                else if (mod_clken[o] && cnt[c] < BM) begin
                    cnt[c]++;
                end
            end else if (turn[c]) begin
                turn[c] = 0;
            end else begin
                for (int k = 1; k <= NM; k++) begin
                    int m;
                    m = (last[c] + k) % NM;
                    if (own[c] < 0 && valid_req(m, c)) begin
                        own[c] = m; last[c] = m; cnt[c] = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        logic [NM-1:0]    eg, ep;
        logic [NC-1:0]    eb, eclk, ewe;
        logic [NC*AW-1:0] ea;
        logic [NC*DW-1:0] ed;
        logic [NM*DW-1:0] eo;
        eg = '0; ep = '0; eb = '0; eclk = '0; ewe = '0; ea = '0; ed = '0; eo = '0;
        for (int c = 0; c < NC; c++) begin
            if (own[c] >= 0) begin
                int m;
                m = own[c];
                eg[m] = 1'b1;
                eb[c] = 1'b1;
                eclk[c] = mod_clken[m];
                ewe[c]  = mod_we[m];
                ea[c*AW +: AW] = mod_addr[m*AW +: AW];
                ed[c*DW +: DW] = mod_data_i[m*DW +: DW];
                eo[m*DW +: DW] = chan_data_o[c*DW +: DW];
            end
        end
        for (int m = 0; m < NM; m++) ep[m] = pre[m];
        check("mod_grant",   64'(mod_grant),   64'(eg));
        check("chan_busy",   64'(chan_busy),   64'(eb));
        check("chan_clken",  64'(chan_clken),  64'(eclk));
        check("chan_we",     64'(chan_we),     64'(ewe));
        check("chan_addr",   64'(chan_addr),   64'(ea));
        check("chan_data_i", 64'(chan_data_i), 64'(ed));
        check("mod_data_o",  64'(mod_data_o),  64'(eo));
        check("mod_preempt", 64'(mod_preempt), 64'(ep));
    endtask

    task automatic step();
        model_clock();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        int seen;
        n_reset      = 1'b0;
        mod_req      = '1;
        mod_chan_sel = '0;
        mod_clken    = '1;
        mod_we       = '1;
        mod_addr     = 36'({$urandom(), $urandom()});
        mod_data_i   = $urandom();
        chan_data_o  = 24'($urandom());
        model_reset();

        // Reset with every request high: all outputs zero.
        repeat (2) @(posedge clk);
        #1;
        check_all();
        check("reset_grant", 64'(mod_grant), 64'h0);
        check("reset_clken", 64'(chan_clken), 64'h0);

        // Release: module 0 has first priority.
        n_reset = 1'b1;
        step();
        check("first_grant_m0", 64'(mod_grant), 64'h1);

        // Prime channel 2 with last owner = 0.
        mod_req = '0;
        step(); step();
        mod_req = 4'b0001; set_sel(0, 2);
        step();
        check("m0_owns_ch2", 64'(chan_busy), 64'h4);
        mod_req = '0;
        step(); step();

        // Modules 1 and 3 contend for channel 2: module 1 wins.
        mod_req = 4'b1010; set_sel(1, 2); set_sel(3, 2);
        step();
        check("rr_m1_wins", 64'(mod_grant), 64'h2);
        mod_req = 4'b1000;
        step();
        check("release_gap", 64'(mod_grant), 64'h0);
        step();
        check("turn_gap", 64'(mod_grant), 64'h0);
        step();
        check("rr_m3_next", 64'(mod_grant), 64'h8);

        // Module 2 owns channel 0: forwarding and read return.
        mod_req = 4'b0100; set_sel(2, 0);
        step();
        check("m2_grant", 64'(mod_grant), 64'h4);
        mod_we = 4'b0100; mod_clken = 4'b0100;
        mod_addr[2*AW +: AW] = 9'h1A5;
        mod_data_i[2*DW +: DW] = 8'h5C;
        chan_data_o = 24'h339977;
        #1;
        check("fwd_we0",   64'(chan_we[0]), 64'h1);
        check("fwd_addr0", 64'(chan_addr[AW-1:0]), 64'h1A5);
        check("fwd_data0", 64'(chan_data_i[DW-1:0]), 64'h5C);
        check("ret_data",  64'(mod_data_o), 64'h0077_0000);
        check_all();

        // Out-of-range select is never granted.
        mod_req = 4'b0001; set_sel(0, 3); mod_clken = '1;
        repeat (4) step();
        check("oor_grant", 64'(mod_grant), 64'h0);
        check("oor_clken", 64'(chan_clken), 64'h0);

`ifdef CHANBUF_PREEMPT_EN
        // Module 1 bursts on channel 1 while module 2 waits.
        mod_req = 4'b0110; set_sel(1, 1); set_sel(2, 1); mod_clken = 4'b0010;
        step();
        check("burst_owner", 64'(mod_grant), 64'h2);
        seen = 0;
        for (int i = 1; i <= 10 && seen == 0; i++) begin
            step();
            if (mod_preempt[1]) seen = i;
        end
        check("preempt_edge", 64'(seen), 64'd5);
        step();
        check("preempt_turn", 64'(mod_grant), 64'h0);
        step();
        check("preempt_m2", 64'(mod_grant), 64'h4);
`endif

        // Asynchronous reset in the middle of a write.
        mod_req = '0;
        step(); step();
        mod_req = 4'b0100; set_sel(2, 0); mod_we = '1; mod_clken = '1;
        step();
        check("pre_rst_we", 64'(chan_we[0]), 64'h1);
        #3;
        n_reset = 1'b0;
        #1;
        model_reset();
        check("async_we", 64'(chan_we), 64'h0);
        check("async_clken", 64'(chan_clken), 64'h0);
        check_all();
        @(posedge clk);
        #1;
        check_all();
        n_reset = 1'b1;
        mod_req = '1; mod_chan_sel = '0;
        step();
        check("post_rst_m0", 64'(mod_grant), 64'h1);

        // Random traffic against the model.
        seen = 0;
        repeat (400) begin
            for (int m = 0; m < NM; m++) begin
                if ($urandom_range(7) == 0) mod_req[m] = ~mod_req[m];
                if ($urandom_range(9) == 0) set_sel(m, int'($urandom_range(3)));
            end
            mod_clken   = 4'($urandom());
            mod_we      = 4'($urandom());
            mod_addr    = 36'({$urandom(), $urandom()});
            mod_data_i  = $urandom();
            chan_data_o = 24'($urandom());
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
